// File: rtl/log2_est32_pkg.sv
// Shared widths for the log2 estimator and its leading-zero counter.
// The result width helper keeps port declarations in step with FRAC_W.
package log2_est32_pkg;

  localparam int DATA_W = 32;
  localparam int LZ_W   = 6;
  localparam int INT_W  = 5;

  function automatic int res_w(input int frac_w);
    return INT_W + frac_w;
  endfunction

endpackage

// File: rtl/log2_est32_cntlz32.sv
// Combinational 32-bit leading-zero counter; returns 32 for a zero operand.
module log2_est32_cntlz32
  import log2_est32_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  output logic [LZ_W-1:0]   lz
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    lz = LZ_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (x[i]) lz = LZ_W'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/log2_est32.sv
// 3-stage log2 estimator: lz count, normalise, compose Q5.FRAC_W result.
// Handshake: beat accepted on in_valid && in_ready, result consumed on out_valid && out_ready; all stages advance together when !out_valid || out_ready.
module log2_est32
  import log2_est32_pkg::*;
#(
  parameter int FRAC_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [res_w(FRAC_W)-1:0]   out_log2,
  output logic [LZ_W-1:0]            out_lz,
  output logic                       out_zero
);

  logic advance;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_x_q, s1_x_d;
  logic [LZ_W-1:0]   s1_lz_q, s1_lz_d;
  logic [LZ_W-1:0]   lz_comb;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_zero_q, s2_zero_d;
  logic [INT_W-1:0]  s2_int_q, s2_int_d;
  logic [FRAC_W-1:0] s2_frac_q, s2_frac_d;
  logic [LZ_W-1:0]   s2_lz_q, s2_lz_d;
  logic [DATA_W-1:0] norm;
  logic              norm_unused;

  logic                      out_valid_q, out_valid_d;
  logic [res_w(FRAC_W)-1:0]  out_log2_q, out_log2_d;
  logic [LZ_W-1:0]           out_lz_q, out_lz_d;
  logic                      out_zero_q, out_zero_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  log2_est32_cntlz32 u_cntlz (
    .x  (in_data),
    .lz (lz_comb)
  );

  // The leading one lands on bit 31, so the fraction is the bits just below it.
  assign norm        = s1_x_q << s1_lz_q;
  assign norm_unused = ^{norm[DATA_W-1], norm[DATA_W-2-FRAC_W:0]};

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_lz_d     = s1_lz_q;
    s2_valid_d  = s2_valid_q;
    s2_zero_d   = s2_zero_q;
    s2_int_d    = s2_int_q;
    s2_frac_d   = s2_frac_q;
    s2_lz_d     = s2_lz_q;
    out_valid_d = out_valid_q;
    out_log2_d  = out_log2_q;
    out_lz_d    = out_lz_q;
    out_zero_d  = out_zero_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s1_x_d      = in_data;
      s1_lz_d     = lz_comb;
      s2_valid_d  = s1_valid_q;
      s2_zero_d   = (s1_lz_q == LZ_W'(DATA_W));
      s2_int_d    = INT_W'(5'd31 - s1_lz_q[INT_W-1:0]);
      s2_frac_d   = norm[DATA_W-2 -: FRAC_W];
      s2_lz_d     = s1_lz_q;
      out_valid_d = s2_valid_q;
      out_log2_d  = s2_zero_q ? '0 : {s2_int_q, s2_frac_q};
      out_lz_d    = s2_lz_q;
      out_zero_d  = s2_zero_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_lz_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_int_q    <= '0;
      s2_frac_q   <= '0;
      s2_lz_q     <= '0;
      out_valid_q <= 1'b0;
      out_log2_q  <= '0;
      out_lz_q    <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_lz_q     <= s1_lz_d;
      s2_valid_q  <= s2_valid_d;
      s2_zero_q   <= s2_zero_d;
      s2_int_q    <= s2_int_d;
      s2_frac_q   <= s2_frac_d;
      s2_lz_q     <= s2_lz_d;
      out_valid_q <= out_valid_d;
      out_log2_q  <= out_log2_d;
      out_lz_q    <= out_lz_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_log2  = out_log2_q;
  assign out_lz    = out_lz_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_log2_est32.sv
// Bench for log2_est32 with FRAC_W = 8: directed beats, backpressure, random streaming, mid-run reset.
module tb_log2_est32;

  localparam int FW = 8;
  localparam int RW = 5 + FW;
  localparam int PW = RW + 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_log2;
  logic [5:0]    out_lz;
  logic          out_zero;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;
  logic [PW-1:0] exp_q[$];

  log2_est32 #(.FRAC_W(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_log2  (out_log2),
    .out_lz    (out_lz),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  // Reference: find the msb, then read the fraction from x / 2^msb in Q32.32.
  function automatic logic [PW-1:0] model(input logic [31:0] x);
    int          msb;
    logic [63:0] t;
    logic [FW-1:0] fr;
    if (x == 32'd0) return {{RW{1'b0}}, 6'd32, 1'b1};
    msb = 31;
    while (!x[msb]) msb--;
    t  = {x, 32'd0} >> msb;
    fr = t[31 -: FW];
    return {5'(msb), fr, 6'(31 - msb), 1'b0};
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge, so the
  // handshakes seen here are exactly the ones the next rising edge takes.
  always @(negedge clk) begin
    logic [PW-1:0] e;
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
      if (out_valid && out_ready) begin
        n_pops++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected got=%h required=none", {out_log2, out_lz, out_zero});
        end else begin
          e = exp_q.pop_front();
          if ({out_log2, out_lz, out_zero} !== e)
            $display("FAIL sb_result got=%h required=%h", {out_log2, out_lz, out_zero}, e);
          else n_pass++;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b required=0", out_valid); else n_pass++;
    n_checks++; if (out_log2 !== '0) $display("FAIL rst_log2 got=%h required=0", out_log2); else n_pass++;
    n_checks++; if (out_lz !== 6'd0) $display("FAIL rst_lz got=%0d required=0", out_lz); else n_pass++;
    n_checks++; if (out_zero !== 1'b0) $display("FAIL rst_zero got=%b required=0", out_zero); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b required=1", in_ready); else n_pass++;
    next_cycle();
  endtask

  task automatic run_single(input logic [31:0] x, input logic [RW-1:0] e_log2,
                            input logic [5:0] e_lz, input logic e_zero);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x;
    next_cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      next_cycle();
      lat++;
    end
    n_checks++; if (lat !== 3) $display("FAIL latency x=%h got=%0d required=3", x, lat); else n_pass++;
    n_checks++; if (out_log2 !== e_log2) $display("FAIL log2 x=%h got=%h required=%h", x, out_log2, e_log2); else n_pass++;
    n_checks++; if (out_lz !== e_lz) $display("FAIL lz x=%h got=%0d required=%0d", x, out_lz, e_lz); else n_pass++;
    n_checks++; if (out_zero !== e_zero) $display("FAIL zero x=%h got=%b required=%b", x, out_zero, e_zero); else n_pass++;
    next_cycle();
  endtask

  task automatic test_single_beats();
    logic [31:0]   xs[6] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'h0000_0003, 32'h0000_1234, 32'h0000_0000};
    logic [RW-1:0] ls[6] = '{13'h000, 13'h1F00, 13'h1FFF, 13'h180, 13'hC23, 13'h000};
    logic [5:0]    zs[6] = '{6'd31, 6'd0, 6'd0, 6'd30, 6'd19, 6'd32};
    logic          zf[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) run_single(xs[i], ls[i], zs[i], zf[i]);
  endtask

  task automatic test_backpressure();
    logic [31:0]   vals[5];
    logic [PW-1:0] snap;
    logic          acc;
    int            idx = 0;
    int            pops0;
    for (int i = 0; i < 5; i++) vals[i] = $urandom;
    pops0     = n_pops;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = vals[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      next_cycle();
      if (acc) begin
        idx++;
        if (idx < 5) in_data = vals[idx];
      end
    end
    n_checks++; if (idx !== 3) $display("FAIL bp_accepted got=%0d required=3", idx); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b required=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b required=1", out_valid); else n_pass++;
    snap = {out_log2, out_lz, out_zero};
    n_checks++; if (snap !== model(vals[0])) $display("FAIL bp_head got=%h required=%h", snap, model(vals[0])); else n_pass++;
    repeat (3) next_cycle();
    n_checks++;
    if ({out_log2, out_lz, out_zero} !== snap || out_valid !== 1'b1)
      $display("FAIL bp_stable got=%h required=%h", {out_log2, out_lz, out_zero}, snap);
    else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (idx < 5 || exp_q.size() > 0 || out_valid); c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      next_cycle();
      if (acc) begin
        idx++;
        if (idx < 5) in_data = vals[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (n_pops - pops0 !== 5) $display("FAIL bp_delivered got=%0d required=5", n_pops - pops0); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_leftover got=%0d required=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_streaming();
    int n = 0;
    int cyc = 0;
    int pops0;
    int shift;
    logic not_ready;
    while (n < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      shift     = $urandom_range(0, 32);
      in_data   = (shift == 32) ? 32'd0 : ($urandom >> shift);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) n++;
      next_cycle();
      cyc++;
    end
    n_checks++; if (n !== 10000) $display("FAIL stream_beats got=%0d required=10000", n); else n_pass++;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = $urandom;
    repeat (4) next_cycle();
    pops0     = n_pops;
    not_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_data = $urandom;
      @(negedge clk);
      if (!in_ready) not_ready = 1'b1;
      next_cycle();
    end
    n_checks++; if (n_pops - pops0 !== 40) $display("FAIL stream_rate got=%0d required=40", n_pops - pops0); else n_pass++;
    n_checks++; if (not_ready !== 1'b0) $display("FAIL stream_in_ready got=%b required=0", not_ready); else n_pass++;
    in_valid = 1'b0;
    repeat (6) next_cycle();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL stream_leftover got=%0d required=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic stale = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd5;
    next_cycle();
    in_data = 32'd7;
    next_cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 6) begin
      next_cycle();
      lat++;
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rm_pre_valid got=%b required=1", out_valid); else n_pass++;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rm_valid got=%b required=0", out_valid); else n_pass++;
    n_checks++; if (out_log2 !== '0) $display("FAIL rm_log2 got=%h required=0", out_log2); else n_pass++;
    n_checks++; if (out_lz !== 6'd0) $display("FAIL rm_lz got=%0d required=0", out_lz); else n_pass++;
    n_checks++; if (out_zero !== 1'b0) $display("FAIL rm_zero got=%b required=0", out_zero); else n_pass++;
    next_cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (out_valid) stale = 1'b1;
    end
    n_checks++; if (stale !== 1'b0) $display("FAIL rm_stale got=%b required=0", stale); else n_pass++;
    run_single(32'd3, 13'h180, 6'd30, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_beats();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    repeat (4) next_cycle();
    n_checks++; if (exp_q.size() !== 0) $display("FAIL final_leftover got=%0d required=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
